// File: rtl/rcc_periph_seq.sv
// rtl/rcc_periph_seq.sv - AHB-Lite peripheral clock/reset sequencer
// Walks one peripheral at a time through clock-on/settle/reset-release or reset/hold/clock-off.
module rcc_periph_seq #(
  parameter int NUM_PERIPH = 4,
  parameter int CLK_SETTLE = 8,
  parameter int RST_HOLD   = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HADDR,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  input  logic                  wdog_rst_req,
  output logic [NUM_PERIPH-1:0] periph_clk_en,
  output logic [NUM_PERIPH-1:0] periph_rst_n,
  output logic                  seq_busy,
  output logic                  irq
);

  localparam logic [7:0] CNT_SETTLE = 8'(CLK_SETTLE - 1);
  localparam logic [7:0] CNT_HOLD   = 8'(RST_HOLD - 1);
  localparam logic [NUM_PERIPH-1:0] P_ONE = NUM_PERIPH'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_HOLD_OFF = 2'd2,
    S_HOLD_SR  = 2'd3
  } state_e;

  state_e                r_state;
  logic [NUM_PERIPH-1:0] r_sel;
  logic [7:0]            r_cnt;
  logic [NUM_PERIPH-1:0] r_clk_en;
  logic [NUM_PERIPH-1:0] r_rst_n;
  logic [NUM_PERIPH-1:0] r_target;
  logic [NUM_PERIPH-1:0] r_swrst;
  logic                  r_done;

  logic                  r_dp_valid;
  logic                  r_dp_write;
  logic [1:0]            r_dp_addr;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_target;
  logic                  w_wr_swrst;
  logic                  w_wr_irqclr;
  logic [NUM_PERIPH-1:0] w_en_req;
  logic [NUM_PERIPH-1:0] w_dis_req;
  logic [NUM_PERIPH-1:0] w_sr_req;
  logic [NUM_PERIPH-1:0] w_pending;
  logic [NUM_PERIPH-1:0] w_pick;
  logic                  w_pick_en;
  logic                  w_pick_dis;
  logic [NUM_PERIPH-1:0] w_sw_set;
  logic [NUM_PERIPH-1:0] w_sw_clr;
  logic                  w_done_set;
  logic [31:0]           w_status;
  logic                  w_unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign w_unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 2'd0;
    end else if (HREADY) begin
      r_dp_valid <= HSEL & HTRANS[1];
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[3:2];
    end
  end

  assign w_wr        = r_dp_valid & r_dp_write & HREADY;
  assign w_rd        = r_dp_valid & ~r_dp_write;
  assign w_wr_target = w_wr & (r_dp_addr == 2'd0);
  assign w_wr_swrst  = w_wr & (r_dp_addr == 2'd1);
  assign w_wr_irqclr = w_wr & (r_dp_addr == 2'd3);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_target <= '0;
    end else if (w_wr_target) begin
      r_target <= HWDATA[NUM_PERIPH-1:0];
    end
  end

  assign w_en_req  = r_target & ~r_clk_en;
  assign w_dis_req = ~r_target & r_clk_en;
  assign w_sr_req  = r_swrst & r_clk_en & r_target;
  assign w_pending = w_en_req | w_dis_req | w_sr_req;
  // Isolate the lowest set bit: that is the peripheral served next.
  assign w_pick     = w_pending & (~w_pending + P_ONE);
  assign w_pick_en  = |(w_pick & w_en_req);
  assign w_pick_dis = |(w_pick & w_dis_req);

  assign w_sw_set   = (w_wr_swrst ? HWDATA[NUM_PERIPH-1:0] : '0) |
                      (wdog_rst_req ? r_clk_en : '0);
  assign w_sw_clr   = ((r_state == S_IDLE) && (|w_pending) && !w_pick_en) ? w_pick : '0;
  assign w_done_set = (r_state != S_IDLE) && (r_cnt == 8'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_cnt    <= 8'd0;
      r_clk_en <= '0;
      r_rst_n  <= '0;
      r_swrst  <= '0;
      r_done   <= 1'b0;
    end else begin
      // Pending soft resets on gated peripherals evaporate; a fresh request beats a clear.
      r_swrst <= (r_swrst & r_clk_en & ~w_sw_clr) | w_sw_set;
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_wr_irqclr && HWDATA[0]) begin
        r_done <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (|w_pending) begin
            r_sel <= w_pick;
            if (w_pick_en) begin
              r_clk_en <= r_clk_en | w_pick;
              r_cnt    <= CNT_SETTLE;
              r_state  <= S_SETTLE;
            end else begin
              r_rst_n <= r_rst_n & ~w_pick;
              r_cnt   <= CNT_HOLD;
              r_state <= w_pick_dis ? S_HOLD_OFF : S_HOLD_SR;
            end
          end
        end
        S_SETTLE, S_HOLD_SR: begin
          if (r_cnt == 8'd0) begin
            r_rst_n <= r_rst_n | r_sel;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HOLD_OFF: begin
          if (r_cnt == 8'd0) begin
            r_clk_en <= r_clk_en & ~r_sel;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign periph_clk_en = r_clk_en;
  assign periph_rst_n  = r_rst_n;
  assign seq_busy      = (r_state != S_IDLE);
  assign irq           = r_done;

  always_comb begin
    w_status = '0;
    w_status[NUM_PERIPH-1:0]   = r_clk_en;
    w_status[16 +: NUM_PERIPH] = r_rst_n;
    w_status[31]               = seq_busy;
    w_status[30]               = r_done;
  end

  always_comb begin
    HRDATA = '0;
    if (w_rd) begin
      case (r_dp_addr)
        2'd0:    HRDATA[NUM_PERIPH-1:0] = r_target;
        2'd1:    HRDATA[NUM_PERIPH-1:0] = r_swrst;
        2'd2:    HRDATA = w_status;
        default: HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_periph_seq.sv
// tb/tb_rcc_periph_seq.sv - self-checking bench for rcc_periph_seq
// Expected output timelines are built from an operation list (kind, peripheral, start, duration).
module tb_rcc_periph_seq;

  localparam int NP     = 4;
  localparam int SETTLE = 8;
  localparam int HOLD   = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic        HREADY = 1'b1;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        wdog_rst_req = 1'b0;
  logic [NP-1:0] periph_clk_en;
  logic [NP-1:0] periph_rst_n;
  logic        seq_busy;
  logic        irq;

  rcc_periph_seq #(.NUM_PERIPH(NP), .CLK_SETTLE(SETTLE), .RST_HOLD(HOLD)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .wdog_rst_req(wdog_rst_req), .periph_clk_en(periph_clk_en),
    .periph_rst_n(periph_rst_n), .seq_busy(seq_busy), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  typedef enum int {OP_EN, OP_DIS, OP_SR} op_kind_e;
  typedef struct { op_kind_e kind; int idx; } op_t;
  op_t ops[$];

  int checks = 0;
  int failures = 0;
  logic [3:0] m_en = '0;
  logic       m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int op_dur(op_kind_e k);
    return (k == OP_EN) ? SETTLE : HOLD;
  endfunction

  // Ops run back to back starting one edge after the triggering write, with one idle edge between.
  function automatic logic [9:0] exp_word(int t, logic [3:0] m0, logic m_irq);
    logic [3:0] c;
    logic [3:0] r;
    logic b;
    logic q;
    int s;
    int d;
    c = m0; r = m0; b = 1'b0; q = m_irq; s = 1;
    foreach (ops[k]) begin
      d = op_dur(ops[k].kind);
      case (ops[k].kind)
        OP_EN: begin
          if (t >= s) c[ops[k].idx] = 1'b1;
          if (t >= s + d) r[ops[k].idx] = 1'b1;
        end
        OP_DIS: begin
          if (t >= s) r[ops[k].idx] = 1'b0;
          if (t >= s + d) c[ops[k].idx] = 1'b0;
        end
        default: begin
          if (t >= s && t < s + d) r[ops[k].idx] = 1'b0;
        end
      endcase
      if (t >= s && t < s + d) b = 1'b1;
      if (t >= s + d) q = 1'b1;
      s = s + d + 1;
    end
    return {q, b, r, c};
  endfunction

  task automatic expect_run(input int t0);
    int total;
    total = 3;
    foreach (ops[k]) total += op_dur(ops[k].kind) + 1;
    for (int t = t0; t <= total; t++) begin
      if (t > t0) begin
        @(posedge HCLK); #1;
      end
      chk($sformatf("timeline t=%0d", t), {22'd0, irq, seq_busy, periph_rst_n, periph_clk_en},
          {22'd0, exp_word(t, m_en, m_done)});
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_write2(input logic [31:0] a1, input logic [31:0] d1,
                            input logic [31:0] a2, input logic [31:0] d2);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a1;
    @(posedge HCLK); #1;
    HADDR = a2; HWDATA = d1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d2;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  task automatic wdog_pulse();
    @(posedge HCLK); #1;
    wdog_rst_req = 1'b1;
    @(posedge HCLK); #1;
    wdog_rst_req = 1'b0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    m_en = '0; m_done = 1'b0; ops.delete();
  endtask

  task automatic enable_mask(input logic [3:0] v);
    ops.delete();
    for (int i = 0; i < NP; i++)
      if (v[i] != m_en[i]) ops.push_back('{v[i] ? OP_EN : OP_DIS, i});
    bus_write(32'h0, {28'd0, v});
    expect_run(0);
    if (ops.size() > 0) m_done = 1'b1;
    m_en = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  v;
    int          sel;

    do_reset();
    chk("rst clk_en", {28'd0, periph_clk_en}, 32'd0);
    chk("rst rst_n", {28'd0, periph_rst_n}, 32'd0);
    chk("rst busy", {31'd0, seq_busy}, 32'd0);
    chk("rst irq", {31'd0, irq}, 32'd0);
    chk("rst hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst hresp", {31'd0, HRESP}, 32'd0);
    chk("rst hrdata idle", HRDATA, 32'd0);
    bus_read(32'h8, rd);
    chk("rst status", rd, 32'h0000_0000);

    enable_mask(4'h1);
    bus_read(32'h8, rd);
    chk("single status", rd, 32'h4001_0001);
    chk("single irq held", {31'd0, irq}, 32'd1);
    bus_write(32'hC, 32'h1);
    m_done = 1'b0;
    chk("irqclr irq", {31'd0, irq}, 32'd0);
    bus_read(32'hC, rd);
    chk("irqclr reads 0", rd, 32'd0);
    bus_read(32'h8, rd);
    chk("status after clr", rd, 32'h0001_0001);

    do_reset();
    enable_mask(4'h5);

    do_reset();
    enable_mask(4'hF);
    ops.delete();
    ops.push_back('{OP_DIS, 1});
    bus_write2(32'h0, 32'hD, 32'h4, 32'h2);
    expect_run(1);
    m_en = 4'hD; m_done = 1'b1;
    bus_read(32'h4, rd);
    chk("swrst cleared", rd, 32'd0);
    bus_read(32'h8, rd);
    chk("dis status", rd, 32'h400D_000D);

    do_reset();
    enable_mask(4'h3);
    ops.delete();
    ops.push_back('{OP_SR, 0});
    ops.push_back('{OP_SR, 1});
    wdog_pulse();
    expect_run(0);
    chk("wdog clocks on", {28'd0, periph_clk_en}, 32'h3);

    do_reset();
    bus_write(32'h0, 32'hF);
    repeat (30) begin
      @(posedge HCLK); #1;
    end
    chk("mid p3 clk on", {28'd0, periph_clk_en}, 32'hF);
    chk("mid p3 settling", {28'd0, periph_rst_n}, 32'h7);
    HRESETn = 1'b0;
    #1;
    chk("async clk_en", {28'd0, periph_clk_en}, 32'd0);
    chk("async rst_n", {28'd0, periph_rst_n}, 32'd0);
    chk("async busy", {31'd0, seq_busy}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (20) @(posedge HCLK);
    #1;
    chk("no resume clk_en", {28'd0, periph_clk_en}, 32'd0);
    chk("no resume busy", {31'd0, seq_busy}, 32'd0);
    bus_read(32'h0, rd);
    chk("target reset", rd, 32'd0);
    m_en = '0; m_done = 1'b0;

    for (int r = 0; r < 12; r++) begin
      sel = $urandom_range(0, 2);
      v = 4'($urandom);
      if (sel == 0) begin
        enable_mask(v);
      end else begin
        ops.delete();
        if (sel == 1) begin
          for (int i = 0; i < NP; i++)
            if (v[i] && m_en[i]) ops.push_back('{OP_SR, i});
          bus_write(32'h4, {28'd0, v});
        end else begin
          for (int i = 0; i < NP; i++)
            if (m_en[i]) ops.push_back('{OP_SR, i});
          wdog_pulse();
        end
        expect_run(0);
        if (ops.size() > 0) m_done = 1'b1;
        bus_read(32'h4, rd);
        chk($sformatf("rnd%0d swrst drained", r), rd, 32'd0);
      end
      if ($urandom_range(0, 1) == 1) begin
        bus_write(32'hC, 32'h1);
        m_done = 1'b0;
      end
      chk($sformatf("rnd%0d irq", r), {31'd0, irq}, {31'd0, m_done});
    end
    bus_read(32'h0, rd);
    chk("final target", rd, {28'd0, m_en});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
